// File: rtl/float_sum_renormalizer.sv
// Post-addition renormalizer: takes a raw sign/exponent/25-bit significand sum,
// normalizes it one shift per clock and packs an IEEE-754 single-precision result.
module float_sum_renormalizer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W+1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_result,
    output logic                    busy
);

    // state   | meaning
    // S_IDLE  | waiting for an operand, in_ready high
    // S_NORM  | one normalization step (or terminal rule) per clock
    // S_DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Exponent is one bit wider than the field so carry overflow is seen before truncation
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [EXP_W:0]          exp_q, exp_d;
    logic [MANT_W+1:0]       mant_q, mant_d;
    logic [EXP_W+MANT_W:0]   result_q, result_d;
    logic [EXP_W:0]          exp_inc;
    logic [EXP_W+MANT_W:0]   result_inf;

    assign exp_inc    = exp_q + EXP_ONE;
    assign result_inf = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exp};
                    mant_d  = in_mant;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                state_d = S_DONE;
                if (exp_q == EXP_MAX) begin
                    result_d = result_inf;
                end else if (mant_q == '0) begin
                    result_d = '0;
                end else if (mant_q[MANT_W+1]) begin
                    exp_d  = exp_inc;
                    mant_d = mant_q >> 1;
                    if (exp_inc >= EXP_MAX)
                        result_d = result_inf;
                    else
                        result_d = {sign_q, exp_inc[EXP_W-1:0], mant_q[MANT_W:1]};
                end else if (mant_q[MANT_W]) begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
                end else if (exp_q <= EXP_ONE) begin
                    // No denormals: flush to a zero that keeps the sign
                    result_d = {sign_q, {(EXP_W+MANT_W){1'b0}}};
                end else begin
                    mant_d  = mant_q << 1;
                    exp_d   = exp_q - EXP_ONE;
                    state_d = S_NORM;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_NORM) || (state_q == S_DONE);
    end

    assign out_result = result_q;

endmodule

// File: tb/tb_float_sum_renormalizer.sv
// Scoreboard bench for float_sum_renormalizer: directed cases, backpressure,
// mid-operation reset and randomized operands against a behavioural model.
module tb_float_sum_renormalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;

    float_sum_renormalizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        bit        s;
        bit [7:0]  e;
        bit [24:0] m;
        bit [31:0] r;
        int        lat;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: hold off, 2: random
    bit   prev_v = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural reference: works from the leading-one position and exponent headroom
    function automatic void model(input bit s, input int e, input int m,
                                  output logic [31:0] r, output int shifts);
        int p, lz, ne, nm;
        shifts = 0;
        if (e == 255) begin
            r = {s, 8'hFF, 23'h0};
        end else if (m == 0) begin
            r = 32'h0;
        end else if (m >= (1 << 24)) begin
            ne = e + 1;
            nm = m >> 1;
            if (ne >= 255) r = {s, 8'hFF, 23'h0};
            else           r = {s, ne[7:0], nm[22:0]};
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            lz = 23 - p;
            if (lz == 0 || e - lz >= 1) begin
                nm = m << lz;
                ne = e - lz;
                r = {s, ne[7:0], nm[22:0]};
                shifts = lz;
            end else begin
                r = {s, 31'h0};
                shifts = (e > 1) ? e - 1 : 0;
            end
        end
    endfunction

    // Monitor: pops on the first cycle of each result, then checks it is held stable
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                chk("busy_inready_in_done", {30'h0, busy, in_ready}, 32'h2);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", 32'h1, 32'h0);
                    end else begin
                        cur = sb.pop_front();
                        chk("result", out_result, cur.res);
                        chk("latency", edge_cnt - cur.acc + 1, cur.lat);
                    end
                end else begin
                    chk("result_stable", out_result, cur.res);
                end
            end
            prev_v = out_valid;
        end
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic send(input bit s, input bit [7:0] e, input bit [24:0] m,
                        input bit [31:0] r, input int lat);
        int n = 0;
        exp_t x;
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'h1, 32'h0);
        end else begin
            x.res = r;
            x.acc = edge_cnt + 1;
            x.lat = lat;
            sb.push_back(x);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        chk("drain_idle", {31'h0, in_ready}, 32'h1);
    endtask

    vec_t dir[8];

    initial begin
        logic [31:0] r;
        int sh, n, e, m;
        bit s;
        exp_t x;

        #200_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int sh, n, e, m;
        bit s;
        exp_t x;

        dir[0] = '{1'b0, 8'd127, 25'h1000000, 32'h40000000, 2};
        dir[1] = '{1'b1, 8'd127, 25'h0800000, 32'hBF800000, 2};
        dir[2] = '{1'b0, 8'd130, 25'h0200000, 32'h40000000, 4};
        dir[3] = '{1'b0, 8'd127, 25'h0000001, 32'h34000000, 25};
        dir[4] = '{1'b0, 8'd254, 25'h1000000, 32'h7F800000, 2};
        dir[5] = '{1'b0, 8'd100, 25'h0000000, 32'h00000000, 2};
        dir[6] = '{1'b1, 8'd2,   25'h0000001, 32'h80000000, 3};
        dir[7] = '{1'b1, 8'd255, 25'h0123456, 32'hFF800000, 2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_out_result", out_result, 32'h0);

        // Directed cases, one at a time
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) begin
            send(dir[i].s, dir[i].e, dir[i].m, dir[i].r, dir[i].lat);
            drain();
        end

        // Backpressure: result held, second operand waits for IDLE
        rdy_mode = 1;
        send(1'b1, 8'd127, 25'h0800000, 32'hBF800000, 2);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", {31'h0, out_valid}, 32'h1);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 8'd130;
        in_mant  = 25'h0200000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
            chk("bp_out_valid_held", {31'h0, out_valid}, 32'h1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", {31'h0, in_ready}, 32'h1);
        chk("bp_idle_out_valid", {31'h0, out_valid}, 32'h0);
        x.res = 32'h40000000;
        x.acc = edge_cnt + 1;
        x.lat = 4;
        sb.push_back(x);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset in the middle of a long shift sequence
        send(1'b0, 8'd127, 25'h0000001, 32'h34000000, 25);
        repeat (10) @(negedge clk);
        chk("mid_norm_busy", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
        chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_out_result", out_result, 32'h0);
        send(1'b0, 8'd130, 25'h0200000, 32'h40000000, 4);
        drain();

        // Randomized operands with random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       e = 255;
                1:       e = 254;
                2:       e = $urandom_range(0, 3);
                default: e = $urandom_range(0, 255);
            endcase
            m = $urandom_range(0, 32'h1FFFFFF) >> $urandom_range(0, 25);
            model(s, e, m, r, sh);
            send(s, e[7:0], m[24:0], r, sh + 2);
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
